// File: rtl/pulse_stretch.sv
// Rising-edge triggered pulse stretcher with programmable width, hold-off gap and drop counter.
// Optional retrigger-in-HIGH behaviour is enabled with `define PULSE_STRETCH_RETRIGGER_EN.
`timescale 1ns/1ps
module pulse_stretch #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         trig,
  input  logic [W-1:0] len,
  input  logic [W-1:0] gap,
  output logic         pout,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] drop_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_HOLD} state_t;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] gap_q, gap_d;
  logic [W-1:0] drop_q, drop_d;
  logic         trig_q;
  logic         pout_q, pout_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         trig_edge;
  logic         drop_ev;
  logic [W-1:0] len_eff;

  assign trig_edge = trig & ~trig_q;
  assign len_eff   = (len == '0) ? ONE : len;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    drop_ev = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig_edge) begin
          state_d = ST_HIGH;
          cnt_d   = len_eff;
          gap_d   = gap;
        end
      end
      ST_HIGH: begin
        if (cnt_q == ONE) begin
          if (gap_q != '0) begin
            state_d = ST_HOLD;
            cnt_d   = gap_q;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
`ifdef PULSE_STRETCH_RETRIGGER_EN
        // A reload overrides the end-of-pulse decision, so done is suppressed too.
        if (trig_edge) begin
          state_d = ST_HIGH;
          cnt_d   = len_eff;
          gap_d   = gap;
        end
`else
        if (trig_edge) drop_ev = 1'b1;
`endif
      end
      ST_HOLD: begin
        if (trig_edge) drop_ev = 1'b1;
        if (cnt_q == ONE) state_d = ST_IDLE;
        else              cnt_d   = cnt_q - ONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so derive them from the next state.
    pout_d = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_HIGH) && (cnt_d == ONE);
    drop_d = (drop_ev && (drop_q != '1)) ? drop_q + ONE : drop_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      drop_q  <= '0;
      trig_q  <= 1'b0;
      pout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      drop_q  <= drop_d;
      trig_q  <= trig;
      pout_q  <= pout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pout     = pout_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed-vector bench for pulse_stretch (W=4); expected waveforms are hand-computed bit masks.
`timescale 1ns/1ps
module tb_pulse_stretch;

  logic       clk;
  logic       rst_n;
  logic       trig;
  logic [3:0] len;
  logic [3:0] gap;
  logic       pout;
  logic       busy;
  logic       done;
  logic [3:0] drop_cnt;

  int n_vec;
  int n_err;
  int exp_drop;

  // Bit k of each vector holds the output observed after the (k-1)th stimulus edge.
  logic [31:0] pout_v, busy_v, done_v;

  pulse_stretch #(.W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .trig     (trig),
    .len      (len),
    .gap      (gap),
    .pout     (pout),
    .busy     (busy),
    .done     (done),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Called at a negedge; trig for posedge c comes from pat[c].
  task automatic run_pat(input logic [31:0] pat, input int n);
    pout_v = '0;
    busy_v = '0;
    done_v = '0;
    for (int c = 0; c < n; c++) begin
      trig = pat[c];
      @(negedge clk);
      pout_v[c+1] = pout;
      busy_v[c+1] = busy;
      done_v[c+1] = done;
    end
    trig = 1'b0;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    exp_drop = 0;
    rst_n    = 1'b0;
    trig     = 1'b0;
    len      = 4'd0;
    gap      = 4'd0;

    // 1: reset state, then a basic 5-cycle pulse
    repeat (3) @(negedge clk);
    chk("reset_outputs", {25'd0, pout, busy, done, drop_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    len = 4'd5; gap = 4'd0;
    run_pat(32'h1, 8);
    chk("t1_pout", pout_v, 32'h0000_003E);
    chk("t1_busy", busy_v, 32'h0000_003E);
    chk("t1_done", done_v, 32'h0000_0020);
    chk("t1_drop", {28'd0, drop_cnt}, 32'd0);

    // 2: len=0 acts as 1; a held trigger yields one pulse only
    len = 4'd0;
    run_pat(32'h000F_FFFF, 24);
    chk("t2_pout", pout_v, 32'h0000_0002);
    chk("t2_done", done_v, 32'h0000_0002);
    chk("t2_busy", busy_v, 32'h0000_0002);

    // 3: len=3 gap=4, edges at 0, 5 (HOLD, dropped) and 8 (first idle cycle)
    len = 4'd3; gap = 4'd4;
    run_pat(32'h0000_0121, 16);
    exp_drop = exp_drop + 1;
    chk("t3_pout", pout_v, 32'h0000_0E0E);
    chk("t3_busy", busy_v, 32'h0000_FEFE);
    chk("t3_done", done_v, 32'h0000_0808);
    chk("t3_drop", {28'd0, drop_cnt}, 32'(exp_drop));

    // 4: len=4 gap=0, second edge while the pulse is high (cnt=3)
    len = 4'd4; gap = 4'd0;
    run_pat(32'h0000_0005, 10);
`ifdef PULSE_STRETCH_RETRIGGER_EN
    // Reload to 4 at the edge: 2 cycles already high + 4 more, one done at the end.
    chk("t4_pout", pout_v, 32'h0000_007E);
    chk("t4_done", done_v, 32'h0000_0040);
`else
    exp_drop = exp_drop + 1;
    chk("t4_pout", pout_v, 32'h0000_001E);
    chk("t4_done", done_v, 32'h0000_0010);
`endif
    chk("t4_drop", {28'd0, drop_cnt}, 32'(exp_drop));

    // 6: asynchronous reset on the 2nd cycle of a 10-cycle pulse
    len = 4'd10; gap = 4'd0;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    chk("t6_pout_before", {31'd0, pout}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_clear", {25'd0, pout, busy, done, drop_cnt}, 32'd0);
    exp_drop = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_pat(32'h0, 8);
    chk("t6_pout_idle", pout_v, 32'h0);
    chk("t6_busy_idle", busy_v, 32'h0);

    // 5: saturation; len=1 gap=15, 8 drops per round including the final HOLD cycle
    len = 4'd1; gap = 4'd15;
    run_pat(32'h0001_5555, 20);
    chk("t5_pout", pout_v, 32'h0000_0002);
    chk("t5_busy", busy_v, 32'h0001_FFFE);
    chk("t5_drop_r1", {28'd0, drop_cnt}, 32'd8);
    run_pat(32'h0001_5555, 20);
    chk("t5_drop_r2", {28'd0, drop_cnt}, 32'd15);
    run_pat(32'h0001_5555, 20);
    chk("t5_drop_r3", {28'd0, drop_cnt}, 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
